alu_op_sequencer: RTL and testbench

//  Front-end controller for the 8-bit ALU datapath (lookahead add, two's-complement sub,

---
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operation sequencer for the 8-bit ALU: accepts one request per handshake, runs it
// (single-cycle ops or an 8-step restoring divide) and holds the result until accepted.
module alu_op_sequencer #(
    parameter int         WIDTH     = 8,
    parameter logic [7:0] DIVZ_QUOT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in RESP, and outputs hold while stalled.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q, zero_q, err_q;

    logic             accept;
    logic             is_div_op;

    // Divider step signals
    logic [WIDTH:0]   rem_sh;
    logic             borrow;
    logic [WIDTH-1:0] trial, rem_next, quo_next, div_pick;

    // Single-cycle execution signals
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff, prod;
    logic [WIDTH-1:0] ex_result;
    logic             ex_carry, ex_err;

    assign accept    = in_valid && in_ready;
    assign is_div_op = (in_op == OP_DIV) || (in_op == OP_REM);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (is_div_op && in_b != '0) ? S_DIV : S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_DIV:  if (cnt_q == LAST_STEP) state_d = S_RESP;
            S_RESP: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The shifted partial remainder keeps its carry bit so divisors above 128 still work.
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        borrow   = rem_sh < {1'b0, b_q};
        trial    = rem_sh[WIDTH-1:0] - b_q;
        rem_next = borrow ? rem_sh[WIDTH-1:0] : trial;
        quo_next = {quo_q[WIDTH-2:0], ~borrow};
        div_pick = (op_q == OP_REM) ? rem_next : quo_next;
    end

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = a_q - b_q;
        prod      = a_q * b_q;
        ex_result = '0;
        ex_carry  = 1'b0;
        ex_err    = 1'b0;
        unique case (op_q)
            OP_ADD: begin ex_result = sum[WIDTH-1:0]; ex_carry = sum[WIDTH]; end
            OP_SUB: begin ex_result = diff; ex_carry = a_q < b_q; end
            OP_MUL: ex_result = prod;
            OP_DIV: begin ex_result = DIVZ_QUOT; ex_err = 1'b1; end
            OP_REM: begin ex_result = a_q; ex_err = 1'b1; end
            OP_CMP: begin
                if (a_q == b_q)        ex_result = '0;
                else if (diff[WIDTH-1]) ex_result = WIDTH'(1);
                else                   ex_result = WIDTH'(2);
            end
            default: ex_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept) begin
                    op_q  <= in_op;
                    a_q   <= in_a;
                    b_q   <= in_b;
                    quo_q <= in_a;
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                S_EXEC: begin
                    res_q   <= ex_result;
                    carry_q <= ex_carry;
                    zero_q  <= (ex_result == '0);
                    err_q   <= ex_err;
                end
                S_DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_STEP) begin
                        res_q   <= div_pick;
                        carry_q <= 1'b0;
                        zero_q  <= (div_pick == '0);
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign out_result = res_q;
    assign out_carry  = carry_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand-written stall/reset sequences,
// and randomized operations scored against an arithmetic reference model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry, out_zero, out_err;
    logic       busy;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected {result, carry, zero, err} per accepted request
    logic [10:0] exp_q[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    alu_op_sequencer #(.WIDTH(8), .DIVZ_QUOT(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ia = a;
        int ib = b;
        int r = 0;
        int d;
        logic c = 1'b0;
        logic e = 1'b0;
        logic [7:0] r8;
        case (op)
            3'd0: begin r = (ia + ib) % 256; c = (ia + ib) > 255; end
            3'd1: begin r = (ia - ib + 256) % 256; c = ia < ib; end
            3'd2: r = (ia * ib) % 256;
            3'd3: if (ib == 0) begin r = 255; e = 1'b1; end else r = ia / ib;
            3'd4: if (ib == 0) begin r = ia; e = 1'b1; end else r = ia % ib;
            3'd5: begin
                d = (ia - ib + 256) % 256;
                r = (ia == ib) ? 0 : (d >= 128 ? 1 : 2);
            end
            default: begin r = 0; e = 1'b1; end
        endcase
        r8 = r[7:0];
        return {r8, c, (r == 0), e};
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [7:0] b);
        return ((op == 3'd3 || op == 3'd4) && b != 0) ? 9 : 2;
    endfunction

    // ---------------- driver ----------------
    // Issues one request, checks latency and outputs, stalls `hold` cycles, then accepts.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [10:0] expv, input int exp_lat, input int hold);
        int          cyc;
        logic        got;
        logic [10:0] snap, want;
        exp_q.push_back(expv);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1'b1;
            else chk("busy_running", busy, 1);
        end
        chk("latency", cyc, exp_lat);
        want = exp_q.pop_front();
        if (!got) return;
        chk("busy_resp", busy, 1);
        chk("in_ready_resp", in_ready, 0);
        chk("result", out_result, want[10:3]);
        chk("flags_czе", {out_carry, out_zero, out_err}, want[2:0]);
        snap = {out_result, out_carry, out_zero, out_err};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            chk("hold_stable", {out_result, out_carry, out_zero, out_err}, snap);
            chk("hold_valid", out_valid, 1);
            chk("hold_no_accept", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_accept", {in_ready, out_valid, busy}, 3'b100);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0]  rop;
        logic [7:0]  ra, rb;
        logic        stray;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 2};
        vecs[1]  = '{3'd3, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 1'b0, 9};
        vecs[2]  = '{3'd4, 8'd200, 8'd7, 8'd4, 1'b0, 1'b0, 1'b0, 9};
        vecs[3]  = '{3'd3, 8'd5, 8'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 2};
        vecs[4]  = '{3'd4, 8'd5, 8'd0, 8'd5, 1'b0, 1'b0, 1'b1, 2};
        vecs[5]  = '{3'd5, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{3'd5, 8'd2, 8'd9, 8'd1, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{3'd5, 8'd9, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{3'd1, 8'd2, 8'd9, 8'hF9, 1'b1, 1'b0, 1'b0, 2};
        vecs[9]  = '{3'd2, 8'hFF, 8'h03, 8'hFD, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{3'd3, 8'd250, 8'd200, 8'd1, 1'b0, 1'b0, 1'b0, 9};
        vecs[11] = '{3'd4, 8'd250, 8'd200, 8'd50, 1'b0, 1'b0, 1'b0, 9};
        vecs[12] = '{3'd3, 8'd255, 8'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 9};
        vecs[13] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 2};
        vecs[14] = '{3'd6, 8'd7, 8'd7, 8'h00, 1'b0, 1'b1, 1'b1, 2};

        do_reset();
        @(negedge clk);
        chk("reset_handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_outputs", {out_result, out_carry, out_zero, out_err}, 11'd0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].err}, vecs[i].lat, i % 3);

        // Long stall on a MUL result
        run_op(3'd2, 8'd12, 8'd11, {8'h84, 3'b000}, 2, 10);

        // Reset in the 4th divide cycle aborts the divide
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd3; in_a = 8'd200; in_b = 8'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_div", {in_ready, out_valid, busy}, 3'b100);
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        chk("no_result_after_abort", stray, 0);
        run_op(3'd7, 8'd1, 8'd2, {8'h00, 3'b011}, 2, 0);

        // Reset while a result is held
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 8'd1; in_b = 8'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_before_rst", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_resp", {in_ready, out_valid, busy}, 3'b100);

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop, rb), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
